// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - word-addressed data memory: combinational core read, one write port, valid/ready host port; optional store counter under DMEM_STORE_CNT_EN
module dmem_responder #(
  parameter int P_DATA_WIDTH      = 32,
  parameter int P_DMEM_ADDR_WIDTH = 8,
  parameter int P_CNT_WIDTH       = 16
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_dmem_we,
  input  logic [P_DMEM_ADDR_WIDTH-1:0] i_dmem_addr,
  input  logic [P_DATA_WIDTH-1:0]      i_dmem_wdata,
  output logic [P_DATA_WIDTH-1:0]      o_dmem_rdata,
  input  logic                         i_host_req_valid,
  output logic                         o_host_req_ready,
  input  logic                         i_host_we,
  input  logic [P_DMEM_ADDR_WIDTH-1:0] i_host_addr,
  input  logic [P_DATA_WIDTH-1:0]      i_host_wdata,
  output logic                         o_host_rsp_valid,
  input  logic                         i_host_rsp_ready,
  output logic [P_DATA_WIDTH-1:0]      o_host_rsp_data,
  output logic [P_CNT_WIDTH-1:0]       o_store_count
);

  localparam int LP_DEPTH = 2 ** P_DMEM_ADDR_WIDTH;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } host_state_t;

  host_state_t             state;
  logic [P_DATA_WIDTH-1:0] mem [LP_DEPTH];
  logic                    host_accept;
  logic                    host_wr_en;

  // Core read path never waits: straight array lookup, old data until the write edge
  assign o_dmem_rdata = mem[i_dmem_addr];

  // Host may only be accepted in IDLE and out of reset; a host write yields to a core write
  assign o_host_req_ready = i_rst_n && (state == ST_IDLE) && !(i_host_we && i_dmem_we);
  assign host_accept      = i_host_req_valid && o_host_req_ready;
  assign host_wr_en       = host_accept && i_host_we;

  // Single write port; the core wins, host writes are only accepted when the core is not writing
  always_ff @(posedge i_clk) begin
    if (i_dmem_we) begin
      mem[i_dmem_addr] <= i_dmem_wdata;
    end else if (host_wr_en) begin
      mem[i_host_addr] <= i_host_wdata;
    end
  end

  // Host request/response FSM with registered response outputs; reset drops a pending response
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state            <= ST_IDLE;
      o_host_rsp_valid <= 1'b0;
      o_host_rsp_data  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (host_accept) begin
            state            <= ST_RESP;
            o_host_rsp_valid <= 1'b1;
            // Reads capture the pre-edge array value, so a same-cycle core write is not seen
            o_host_rsp_data  <= i_host_we ? i_host_wdata : mem[i_host_addr];
          end
        end
        ST_RESP: begin
          if (i_host_rsp_ready) begin
            state            <= ST_IDLE;
            o_host_rsp_valid <= 1'b0;
          end
        end
        default: begin
          state            <= ST_IDLE;
          o_host_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef DMEM_STORE_CNT_EN
  logic [P_CNT_WIDTH-1:0] store_count;

  // Saturating count of core stores, cleared only by reset
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      store_count <= '0;
    end else if (i_dmem_we && (store_count != {P_CNT_WIDTH{1'b1}})) begin
      store_count <= store_count + 1'b1;
    end
  end

  assign o_store_count = store_count;
`else
  assign o_store_count = '0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - randomized and directed self-checking bench for dmem_responder against a behavioural model
module tb_dmem_responder;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int CW = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk;
  logic          rst_n;
  logic          dmem_we;
  logic [AW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata;
  logic [DW-1:0] dmem_rdata;
  logic          host_req_valid;
  logic          host_req_ready;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_rsp_valid;
  logic          host_rsp_ready;
  logic [DW-1:0] host_rsp_data;
  logic [CW-1:0] store_count;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [DW-1:0] m_mem [256];
  bit            m_known [256];
  bit            m_pend;
  logic [DW-1:0] m_data;
  bit            m_data_known;
  int            m_cnt;

  dmem_responder #(
    .P_DATA_WIDTH(DW),
    .P_DMEM_ADDR_WIDTH(AW),
    .P_CNT_WIDTH(CW)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_dmem_we(dmem_we),
    .i_dmem_addr(dmem_addr),
    .i_dmem_wdata(dmem_wdata),
    .o_dmem_rdata(dmem_rdata),
    .i_host_req_valid(host_req_valid),
    .o_host_req_ready(host_req_ready),
    .i_host_we(host_we),
    .i_host_addr(host_addr),
    .i_host_wdata(host_wdata),
    .o_host_rsp_valid(host_rsp_valid),
    .i_host_rsp_ready(host_rsp_ready),
    .o_host_rsp_data(host_rsp_data),
    .o_store_count(store_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] cnt_exp();
`ifdef DMEM_STORE_CNT_EN
    return DW'(m_cnt);
`else
    return '0;
`endif
  endfunction

  task automatic model_reset();
    m_pend       = 1'b0;
    m_data       = '0;
    m_data_known = 1'b1;
    m_cnt        = 0;
  endtask

  // One clock cycle, entered and left at a falling edge: drive, check pre-edge outputs, advance model
  task automatic cycle(input logic cwe, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                       input logic hv, input logic hw, input logic [AW-1:0] ha,
                       input logic [DW-1:0] hd, input logic rr);
    bit            exp_ready;
    bit            acc;
    logic [DW-1:0] old_val;
    bit            old_known;
    dmem_we = cwe; dmem_addr = ca; dmem_wdata = cd;
    host_req_valid = hv; host_we = hw; host_addr = ha; host_wdata = hd;
    host_rsp_ready = rr;
    #1;
    exp_ready = rst_n && !m_pend && !(hw && cwe);
    check("req_ready", {31'b0, host_req_ready}, {31'b0, exp_ready});
    check("rsp_valid", {31'b0, host_rsp_valid}, {31'b0, m_pend});
    if (m_data_known) check("rsp_data", host_rsp_data, m_data);
    if (m_known[ca]) check("dmem_rdata", dmem_rdata, m_mem[ca]);
    check("store_count", DW'(store_count), cnt_exp());
    @(posedge clk);
    acc       = hv && exp_ready;
    old_val   = m_mem[ha];
    old_known = m_known[ha];
    if (rst_n) begin
      if (m_pend && rr) m_pend = 1'b0;
      if (acc) begin
        m_pend       = 1'b1;
        m_data       = hw ? hd : old_val;
        m_data_known = hw || old_known;
      end
      if (cwe && m_cnt < CNT_MAX) m_cnt++;
    end
    if (cwe) begin
      m_mem[ca] = cd; m_known[ca] = 1'b1;
    end else if (acc && hw) begin
      m_mem[ha] = hd; m_known[ha] = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic rr);
    cycle(1'b0, 8'h00, '0, 1'b0, 1'b0, 8'h00, '0, rr);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      m_known[i] = 1'b0;
      m_mem[i]   = '0;
    end
    model_reset();
    rst_n = 1'b0;
    dmem_we = 0; dmem_addr = 0; dmem_wdata = 0;
    host_req_valid = 1'b1; host_we = 0; host_addr = 0; host_wdata = 0; host_rsp_ready = 0;
    @(negedge clk); @(negedge clk);
    check("rst_rsp_valid", {31'b0, host_rsp_valid}, 32'd0);
    check("rst_rsp_data", host_rsp_data, 32'd0);
    check("rst_req_ready", {31'b0, host_req_ready}, 32'd0);
    check("rst_store_count", DW'(store_count), 32'd0);
    rst_n = 1'b1;

    // host write 0x10, core reads it back on the next cycle
    cycle(1'b0, 8'h10, '0, 1'b1, 1'b1, 8'h10, 32'hDEADBEEF, 1'b0);
    check("t1_rsp_valid", {31'b0, host_rsp_valid}, 32'd1);
    check("t1_rdata", dmem_rdata, 32'hDEADBEEF);
    check("t1_echo", host_rsp_data, 32'hDEADBEEF);
    idle(1'b1);

    // core store then host read
    cycle(1'b1, 8'h20, 32'h12345678, 1'b0, 1'b0, 8'h00, '0, 1'b0);
    cycle(1'b0, 8'h20, '0, 1'b1, 1'b0, 8'h20, '0, 1'b0);
    check("t2_rsp_valid", {31'b0, host_rsp_valid}, 32'd1);
    check("t2_rsp_data", host_rsp_data, 32'h12345678);
    idle(1'b1);

    // host write blocked by core write, accepted next cycle
    cycle(1'b1, 8'h31, 32'hAAAA0000, 1'b1, 1'b1, 8'h30, 32'h5555FFFF, 1'b0);
    check("t3_not_accepted", {31'b0, host_rsp_valid}, 32'd0);
    cycle(1'b0, 8'h31, '0, 1'b1, 1'b1, 8'h30, 32'h5555FFFF, 1'b0);
    check("t3_rsp_data", host_rsp_data, 32'h5555FFFF);
    idle(1'b1);
    cycle(1'b0, 8'h30, '0, 1'b0, 1'b0, 8'h00, '0, 1'b0);
    cycle(1'b0, 8'h31, '0, 1'b0, 1'b0, 8'h00, '0, 1'b0);

    // same-address race: host sees old data, core sees new
    cycle(1'b0, 8'h40, '0, 1'b1, 1'b1, 8'h40, 32'd1, 1'b0);
    idle(1'b1);
    cycle(1'b1, 8'h40, 32'd2, 1'b1, 1'b0, 8'h40, '0, 1'b0);
    check("t4_rsp_old", host_rsp_data, 32'd1);
    cycle(1'b0, 8'h40, '0, 1'b0, 1'b0, 8'h00, '0, 1'b1);

    // backpressure hold then reset mid-response
    cycle(1'b0, 8'h00, '0, 1'b1, 1'b0, 8'h10, '0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, '0, 1'b1, 1'b0, 8'h20, '0, 1'b0);
    check("t5_held_data", host_rsp_data, 32'hDEADBEEF);
    check("t5_held_valid", {31'b0, host_rsp_valid}, 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("t5_rst_valid", {31'b0, host_rsp_valid}, 32'd0);
    check("t5_rst_ready", {31'b0, host_req_ready}, 32'd0);
    model_reset();
    @(negedge clk);
    idle(1'b0);
    rst_n = 1'b1;
    cycle(1'b0, 8'h40, '0, 1'b0, 1'b0, 8'h00, '0, 1'b0);
    check("t5_mem_kept", dmem_rdata, 32'd2);

    // 20 core stores saturate a 4-bit counter
    for (int i = 0; i < 20; i++) cycle(1'b1, 8'(8'h50 + i), DW'(i), 1'b0, 1'b0, 8'h00, '0, 1'b0);
`ifdef DMEM_STORE_CNT_EN
    check("t6_saturated", DW'(store_count), 32'd15);
`else
    check("t6_absent", DW'(store_count), 32'd0);
`endif

    // randomized traffic over a small address window to force collisions
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom % 3) == 0, 8'($urandom_range(0, 15)), $urandom,
            ($urandom % 4) != 0, $urandom_range(0, 1), 8'($urandom_range(0, 15)), $urandom,
            ($urandom % 3) != 0);
    end
    for (int a = 0; a < 16; a++) cycle(1'b0, 8'(a), '0, 1'b0, 1'b0, 8'h00, '0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Word-addressed data memory that answers the core's data-memory interface: asynchronous read, synchronous write, with no wait states toward the core. It also provides a host port with a valid/ready request/response handshake for loading data and reading results while the core runs. The block sits outside the core, at the top level, next to the instruction memory.

## Interface
- P_DATA_WIDTH, 32, data word width
- P_DMEM_ADDR_WIDTH, 8, word address width; depth = 2**P_DMEM_ADDR_WIDTH
- P_CNT_WIDTH, 16, store-counter width (used only with DMEM_STORE_CNT_EN)

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- i_dmem_we  in  1  core write enable
- i_dmem_addr  in  P_DMEM_ADDR_WIDTH  core word address
- i_dmem_wdata  in  P_DATA_WIDTH  core write data
- o_dmem_rdata  out  P_DATA_WIDTH  core read data, combinational from i_dmem_addr
- i_host_req_valid  in  1  host request valid
- o_host_req_ready  out  1  host request accepted this cycle when high with valid
- i_host_we  in  1  host request is a write
- i_host_addr  in  P_DMEM_ADDR_WIDTH  host word address
- i_host_wdata  in  P_DATA_WIDTH  host write data
- o_host_rsp_valid  out  1  host response valid
- i_host_rsp_ready  in  1  host consumes response
- o_host_rsp_data  out  P_DATA_WIDTH  read data, or the written data echoed for writes
- o_store_count  out  P_CNT_WIDTH  saturating count of core stores

## Operation
- Storage: array of 2**P_DMEM_ADDR_WIDTH words. Contents are not reset; the host loads them.
- Core read:
  - o_dmem_rdata = mem[i_dmem_addr], combinational, every cycle.
  - The core never stalls on this block.
- Core write: when i_dmem_we=1, mem[i_dmem_addr] <= i_dmem_wdata at the rising edge.
- Single write port; the core has absolute priority.
- Host FSM has two states:
  - IDLE:
    - o_host_req_ready = !(i_host_we && i_dmem_we).
    - A host read is never blocked. A host write is blocked only while the core writes.
    - On accept (valid && ready): a write updates mem[i_host_addr] and latches i_host_wdata into o_host_rsp_data. A read latches mem[i_host_addr] (pre-edge value) into o_host_rsp_data.
    - Go to RESP.
  - RESP:
    - o_host_req_ready=0, o_host_rsp_valid=1.
    - o_host_rsp_data is held stable.
    - On i_host_rsp_ready=1, go to IDLE.
- Collisions:
  - Host read and core write to the same address in the same cycle: the host gets the old data.
  - Core read of an address being written by either port returns the old data until the edge.
- Reset mid-RESP: the pending response is dropped and the FSM returns to IDLE; memory contents are kept.

## Timing
- Core read latency: 0 cycles (combinational). Write visible to reads in the cycle after the edge.
- Host: request accepted at edge N; o_host_rsp_valid=1 during cycle N+1.
- The earliest next accept is the edge after the response handshake, so sustained throughput is 1 request per 2 cycles.
- Reset values: state IDLE, o_host_rsp_valid=0, o_host_rsp_data=0, o_store_count=0.
- During reset o_host_req_ready=0. o_dmem_rdata still reflects the array.

## Configuration
- DMEM_STORE_CNT_EN defined:
  - o_store_count increments by 1 on every edge with i_dmem_we=1.
  - It saturates at 2**P_CNT_WIDTH-1 and does not wrap.
  - It is cleared only by reset.
- Undefined: the counter logic is absent and o_store_count is tied to 0.

## Test plan
- Host write: addr 0x10, data 0xDEADBEEF, then core reads addr 0x10 -> o_dmem_rdata=0xDEADBEEF on the cycle after the host accept edge; rsp_data echoes 0xDEADBEEF.
- Core store then host read: core writes 0x12345678 to 0x20; host reads 0x20 -> o_host_rsp_valid one cycle after accept, data 0x12345678.
- Write collision: host write to 0x30 while i_dmem_we=1 (core writes 0xAAAA0000 to 0x31) -> o_host_req_ready=0 that cycle; the host write is accepted the next cycle; both locations hold their values.
- Read/write same-address race: mem[0x40]=1, core writes 2 to 0x40 in the same cycle the host read of 0x40 is accepted -> rsp_data=1, core reads 2 next cycle.
- Backpressure: i_host_rsp_ready=0 for 5 cycles -> rsp_valid and rsp_data held stable, req_ready=0 throughout. Assert i_rst_n=0 mid-hold -> rsp_valid=0 immediately.
- With DMEM_STORE_CNT_EN and P_CNT_WIDTH=4: 20 core stores -> o_store_count=15, saturated. Without the macro -> 0.
